// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, with a registered borrow between beats and a parallel result.
// Optional signed-overflow flag (ovf_o) is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             a_bit_i,
    input  logic             b_bit_i,
    input  logic             bit_valid_i,
    output logic             bit_ready_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             busy_o,
    output logic             done_o
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               br_q, br_d;
    logic               borrow_q, borrow_d;
    logic               accept;
    logic               last;
    logic               d_bit;
    logic               br_next;
`ifdef SERIAL_SUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            diff_q   <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            diff_q   <= diff_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        diff_d   = diff_q;
        br_d     = br_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        accept   = (state_q == S_SHIFT) && bit_valid_i;
        last     = (cnt_q == CNT_W'(WIDTH - 1));
        d_bit    = a_bit_i ^ b_bit_i ^ br_q;
        br_next  = (~a_bit_i & b_bit_i) | (~(a_bit_i ^ b_bit_i) & br_q);

        unique case (state_q)
            S_IDLE: begin
                // diff/borrow deliberately keep the previous result until this op completes
                if (start_i) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                end
            end
            S_SHIFT: begin
                if (accept) begin
                    shreg_d = {d_bit, shreg_q[WIDTH-1:1]};
                    br_d    = br_next;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last) begin
                        state_d  = S_DONE;
                        diff_d   = {d_bit, shreg_q[WIDTH-1:1]};
                        borrow_d = br_next;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_d    = (a_bit_i != b_bit_i) && (d_bit != a_bit_i);
`endif
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bit_ready_o = (state_q == S_SHIFT);
    assign busy_o      = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign done_o      = (state_q == S_DONE);
    assign diff_o      = diff_q;
    assign borrow_o    = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, abort/start-noise sequences, random ops.
// Overflow checks are included when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int MAX_CYC = 200;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             a_bit;
    logic             b_bit;
    logic             bit_valid;
    logic             bit_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .a_bit_i     (a_bit),
        .b_bit_i     (b_bit),
        .bit_valid_i (bit_valid),
        .bit_ready_o (bit_ready),
        .diff_o      (diff),
        .borrow_o    (borrow),
        .busy_o      (busy),
        .done_o      (done)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf_o       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         mode;        // 0: no bubbles, 1: bubble on alternate cycles, 2: random bubbles
        logic [7:0] exp_diff;
        logic       exp_borrow;
        int         exp_cycles;
    } vec_t;

    vec_t       vecs[9];
    logic [7:0] prev_diff;
    logic       prev_borrow;
    logic       prev_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic model_ovf(input logic [7:0] a, input logic [7:0] b);
        int r;
        r = int'($signed(a)) - int'($signed(b));
        return (r > 127) || (r < -128);
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int mode,
                          input bit start_noise, output int cycles);
        logic [7:0] exp_d;
        logic       exp_b;
        logic [7:0] aa;
        logic [7:0] bb;
        int         i;
        bit         v;
        aa    = a;
        bb    = b;
        exp_d = a - b;
        exp_b = (a < b);
        // A pair offered alongside start must not be consumed
        start     = 1'b1;
        bit_valid = 1'b1;
        a_bit     = ~aa[0];
        b_bit     = ~bb[0];
        step();
        start = start_noise;
        chk("hold_diff", diff, prev_diff);
        chk("hold_borrow", borrow, prev_borrow);
        i      = 0;
        cycles = 0;
        while (i < WIDTH && cycles < MAX_CYC) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cycles % 2) == 1;
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            bit_valid = v;
            a_bit     = v ? aa[i] : 1'($urandom);
            b_bit     = v ? bb[i] : 1'($urandom);
            chk("ready_shift", bit_ready, 1);
            chk("busy_shift", busy, 1);
            chk("no_early_done", done, 0);
            chk("diff_stable", diff, prev_diff);
            step();
            cycles++;
            if (v) i++;
        end
        if (i < WIDTH) chk("accept_timeout", i, WIDTH);
        bit_valid = 1'b0;
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 1);
        chk("ready_done", bit_ready, 0);
        chk("diff", diff, exp_d);
        chk("borrow", borrow, exp_b);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", ovf, model_ovf(a, b));
        prev_ovf = model_ovf(a, b);
`endif
        step();
        start = 1'b0;
        chk("done_single", done, 0);
        chk("busy_idle", busy, 0);
        chk("ready_idle", bit_ready, 0);
        chk("diff_held", diff, exp_d);
        prev_diff   = exp_d;
        prev_borrow = exp_b;
    endtask

    initial begin
        int cyc;
        vecs[0] = '{8'h5A, 8'h3C, 0, 8'h1E, 1'b0, 8};
        vecs[1] = '{8'h00, 8'h01, 0, 8'hFF, 1'b1, 8};
        vecs[2] = '{8'h01, 8'h01, 0, 8'h00, 1'b0, 8};
        vecs[3] = '{8'hC3, 8'h42, 1, 8'h81, 1'b0, 16};
        vecs[4] = '{8'h80, 8'h01, 0, 8'h7F, 1'b0, 8};
        vecs[5] = '{8'h05, 8'h03, 0, 8'h02, 1'b0, 8};
        vecs[6] = '{8'hFF, 8'hFF, 1, 8'h00, 1'b0, 16};
        vecs[7] = '{8'h00, 8'hFF, 0, 8'h01, 1'b1, 8};
        vecs[8] = '{8'h7F, 8'h80, 0, 8'hFF, 1'b1, 8};

        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        prev_diff = 8'h00; prev_borrow = 1'b0; prev_ovf = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", bit_ready, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        step();

        for (int k = 0; k < 9; k++) begin
            run_op(vecs[k].a, vecs[k].b, vecs[k].mode, 1'b0, cyc);
            chk("tbl_diff", diff, vecs[k].exp_diff);
            chk("tbl_borrow", borrow, vecs[k].exp_borrow);
            chk("tbl_latency", cyc, vecs[k].exp_cycles);
            if (k % 2 == 0) step();
        end

        // Abort after four accepted pairs
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bit_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_diff", diff, 0);
        chk("abort_borrow", borrow, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", bit_ready, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("abort_ovf", ovf, 0);
`endif
        for (int k = 0; k < 12; k++) begin
            bit_valid = 1'($urandom);
            a_bit = 1'($urandom);
            b_bit = 1'($urandom);
            step();
            chk("abort_no_done", done, 0);
            chk("abort_idle", busy, 0);
        end
        bit_valid = 1'b0;
        prev_diff = 8'h00; prev_borrow = 1'b0;
        run_op(8'h10, 8'h01, 0, 1'b0, cyc);
        chk("after_abort_diff", diff, 8'h0F);

        // start held high through SHIFT and DONE must be ignored
        run_op(8'h9C, 8'h27, 0, 1'b1, cyc);
        chk("noise_latency", cyc, 8);
        run_op(8'h33, 8'hE1, 2, 1'b1, cyc);
        step();
        chk("noise_idle", busy, 0);

        for (int k = 0; k < 40; k++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, 2, 1'($urandom), cyc);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
